// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues in-order requests over a split
// address/data handshake and buffers returned words for decode.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        de_ready,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_instruction,
  output logic [5:0]  de_opcode,
  output logic [4:0]  de_rs,
  output logic [4:0]  de_rt,
  output logic [4:0]  de_rd,
  output logic [5:0]  de_funct,
  output logic        de_addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      pc;
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_filled;
  logic [DEPTH-1:0] q_err;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    fill_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    pend_cnt;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    redir_drop;
  logic             err_stop;

  logic can_fetch;
  logic req_acc;
  logic alloc_err;
  logic fill;
  logic drop_ok;
  logic pop;

  assign can_fetch = (count < CW'(DEPTH)) && (drop_cnt == '0) && !err_stop;
  assign inst_req  = can_fetch && (pc[1:0] == 2'b00);
  assign inst_addr = pc;
  assign req_acc   = inst_req && inst_addr_ok;
  assign alloc_err = can_fetch && (pc[1:0] != 2'b00);

  // Requests are filled strictly in order, so a single fill pointer tracks the
  // oldest unfilled entry; pend_cnt guards it against stray responses.
  assign fill    = inst_data_ok && (drop_cnt == '0) && (pend_cnt != '0);
  assign drop_ok = inst_data_ok && (drop_cnt != '0);

  assign de_valid = q_filled[head] && !redirect_valid;
  assign pop      = de_valid && de_ready;

  assign redir_drop = pend_cnt + CW'(req_acc) - CW'(fill)
                    + (drop_ok ? drop_cnt - CW'(1) : drop_cnt);

  assign de_pc          = q_pc[head];
  assign de_instruction = q_instr[head];
  assign de_addr_err    = q_err[head];
  assign de_opcode      = de_instruction[31:26];
  assign de_rs          = de_instruction[25:21];
  assign de_rt          = de_instruction[20:16];
  assign de_rd          = de_instruction[15:11];
  assign de_funct       = de_instruction[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      err_stop <= 1'b0;
      q_filled <= '0;
      q_err    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything in flight (including a request accepted this very cycle)
      // is owed a response that must be thrown away.
      pc       <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= redir_drop;
      err_stop <= 1'b0;
      q_filled <= '0;
      q_err    <= '0;
    end else begin
      if (drop_ok)
        drop_cnt <= drop_cnt - CW'(1);
      if (req_acc) begin
        q_pc[tail]     <= pc;
        q_filled[tail] <= 1'b0;
        q_err[tail]    <= 1'b0;
        tail           <= tail + AW'(1);
        pc             <= pc + 32'd4;
      end else if (alloc_err) begin
        q_pc[tail]     <= pc;
        q_instr[tail]  <= '0;
        q_filled[tail] <= 1'b1;
        q_err[tail]    <= 1'b1;
        tail           <= tail + AW'(1);
        err_stop       <= 1'b1;
      end
      if (fill) begin
        q_instr[fill_ptr]  <= inst_rdata;
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + AW'(1);
      end
      if (pop) begin
        q_filled[head] <= 1'b0;
        q_err[head]    <= 1'b0;
        head           <= head + AW'(1);
      end
      count    <= count + CW'(req_acc | alloc_err) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(req_acc) - CW'(fill);
    end
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch stage that sits directly upstream of the decoder. It owns the PC, issues in-order requests to the instruction memory over an address/data split handshake, and buffers returned words in a small queue. It presents one instruction per cycle to decode, together with the pre-split opcode, rt, rd and funct fields that the decoder consumes. Branch and exception redirects flush the queue and discard any responses still in flight.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC loaded at reset.
- `DEPTH`, default 4: number of queue entries; must be a power of 2 and at least 2. It also caps the number of outstanding requests.

- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_req` out 1: request valid toward instruction memory.
- `inst_addr` out 32: request address; equals the current PC.
- `inst_addr_ok` in 1: memory accepts the request this cycle.
- `inst_rdata` in 32: returned instruction word.
- `inst_data_ok` in 1: `inst_rdata` is valid this cycle; responses return in request order.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC.
- `de_ready` in 1: decode accepts the head entry.
- `de_valid` out 1: head entry is valid.
- `de_pc` out 32: PC of the head entry.
- `de_instruction` out 32: instruction word of the head entry.
- `de_opcode` out 6: `de_instruction[31:26]`.
- `de_rs` out 5: `de_instruction[25:21]`.
- `de_rt` out 5: `de_instruction[20:16]`.
- `de_rd` out 5: `de_instruction[15:11]`.
- `de_funct` out 6: `de_instruction[5:0]`.
- `de_addr_err` out 1: head entry is a fetch address error (AdEL); its instruction field is 32'h0.

## Operation
- **State:**
  - `pc`.
  - Circular queue of DEPTH entries, each holding {pc, instr, filled, addr_err}.
  - Head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` of log2(DEPTH)+1 bits.
  - `drop_cnt` of log2(DEPTH)+1 bits.
  - `err_stop` flag.
- **Allocation:** an entry is allocated at the tail on each accepted request (`inst_req & inst_addr_ok`). It records `pc` with `filled`=0, and `pc` then advances by 4 (32-bit wrap).
- **Fill:** on `inst_data_ok` with `drop_cnt`==0, the oldest unfilled entry gets `instr`=`inst_rdata` and `filled`=1. A data_ok arriving with no unfilled entry and `drop_cnt`==0 is ignored; this is a protocol violation flagged by bench assertion.
- **Request condition:** `inst_req` = (`count` < DEPTH) & (`drop_cnt`==0) & ~`err_stop` & (`pc[1:0]`==0).
- **Misaligned PC:** when `pc[1:0]`!=0, `count` < DEPTH, `drop_cnt`==0 and ~`err_stop`:
  - allocate one entry with `filled`=1, `addr_err`=1, `instr`=0;
  - set `err_stop`; no memory request is made.
  - Fetch then idles until a redirect.
- **Output:** `de_valid` = head.`filled` & ~`redirect_valid`. Pop happens on `de_valid & de_ready`. The predecode fields are purely combinational slices of the head `instr`.
- **Redirect** (highest priority, same edge):
  - `pc` <= `redirect_pc`.
  - All entries are invalidated; head = tail = 0; `count` = 0; `err_stop` = 0.
  - `drop_cnt` <= (number of allocated-unfilled entries) + (1 if a request is accepted this cycle) − (1 if a non-dropped data_ok arrives this cycle) + (`drop_cnt` − 1 if a dropped data_ok arrives this cycle, else `drop_cnt`).
  - A pop in the same cycle is void.
- **Drop:** while `drop_cnt` > 0, each `inst_data_ok` decrements it and the data is discarded.
- **Simultaneous events:**
  - Allocate and pop in the same cycle leave `count` unchanged.
  - Fill and pop of the same entry cannot coincide, because `filled` is registered.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`; queue empty; `drop_cnt`=0; `err_stop`=0.
  - `de_valid`=0 and `de_addr_err`=0. `de_instruction`, `de_pc` and the predecode fields are 0 (all entries clear).
  - `inst_req`=1 and `inst_addr`=`RESET_PC` in the first cycle after reset release.
- **Latency:** data_ok in cycle N gives `de_valid`=1 in cycle N+1. With zero-wait memory (addr_ok in cycle T, data_ok in T+1), the first `de_valid` appears at T+2, and sustained throughput is 1 instruction/cycle.
- **Handshake:** `inst_addr` is held stable while `inst_req`=1 and `inst_addr_ok`=0, unless `redirect_valid` is asserted. On redirect, `inst_req` and `inst_addr` may change the next cycle.
- **Full:** with `count`==DEPTH, `inst_req`=0; a pop that cycle re-enables requests the next cycle.
- **Redirect:** `de_valid`=0 in the redirect cycle. The first request to `redirect_pc` comes the next cycle if `drop_cnt` is 0, otherwise the cycle after the last dropped data_ok.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. In-flight memory responses after reset release are the memory's responsibility and are not dropped.

## Test plan
- **Reset streaming:** reset, zero-wait memory returning addr as data, `de_ready`=1 → requests at BFC00000, BFC00004, …; `de_valid` from cycle 2; `de_pc`/`de_instruction` in order; 1 per cycle.
- **Backpressure:** `de_ready`=0 for 10 cycles, DEPTH=4 → exactly 4 accepted requests, then `inst_req`=0; releasing `de_ready` drains BFC00000..BFC0000C in order, then fetch resumes.
- **Flush with in-flight responses:** 3 outstanding requests (data latency 3), redirect to 80000100 → 3 data_ok discarded; no `de_valid` until the response for 80000100; next `de_pc`=80000100.
- **Misaligned redirect:** redirect to 80000102 → no `inst_req`; one entry with `de_addr_err`=1, `de_pc`=80000102, instr 0; fetch idles until redirect to 80000200 resumes normally.
- **Redirect/accept coincidence:** redirect in the same cycle as addr_ok for BFC00008 → that response is dropped and `drop_cnt` includes it; ADDIU word 24020005 fetched later shows `de_opcode`=001001, `de_rt`=2, `de_funct`=000101.
